// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_unit
// Description : HI/LO write pipeline (M and W slots), architectural HI/LO
//               registers and per-half forwarding to the EX-stage multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  ex_we,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    output logic [31:0] hi_fwd,
    output logic [31:0] lo_fwd,
    output logic [31:0] arch_hi,
    output logic [31:0] arch_lo,
    output logic        pending
);

    localparam logic [1:0]  C_WE_NONE = 2'b00;
    localparam logic [31:0] C_ZERO    = 32'h0000_0000;
    localparam int          C_HI      = 1;
    localparam int          C_LO      = 0;

    logic [1:0]  r_m_we;
    logic [31:0] r_m_hi;
    logic [31:0] r_m_lo;
    logic [1:0]  r_w_we;
    logic [31:0] r_w_hi;
    logic [31:0] r_w_lo;
    logic [31:0] r_arch_hi;
    logic [31:0] r_arch_lo;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_m_we    <= C_WE_NONE;
            r_m_hi    <= C_ZERO;
            r_m_lo    <= C_ZERO;
            r_w_we    <= C_WE_NONE;
            r_w_hi    <= C_ZERO;
            r_w_lo    <= C_ZERO;
            r_arch_hi <= C_ZERO;
            r_arch_lo <= C_ZERO;
        end else begin
            if (r_w_we[C_HI]) r_arch_hi <= r_w_hi;
            if (r_w_we[C_LO]) r_arch_lo <= r_w_lo;

            // The instruction leaving M is past the exception point, so a
            // flush does not stop it from advancing into W.
            if (!stall) begin
                r_w_we <= r_m_we;
                r_w_hi <= r_m_hi;
                r_w_lo <= r_m_lo;
            end else begin
                r_w_we <= C_WE_NONE;
            end

            if (flush) begin
                r_m_we <= C_WE_NONE;
            end else if (!stall) begin
                r_m_we <= ex_we;
                r_m_hi <= ex_hi;
                r_m_lo <= ex_lo;
            end
        end
    end

    // Newest enabled copy wins, chosen independently per half; EX inputs are
    // deliberately excluded to keep the multiplier path free of loops.
    assign hi_fwd  = r_m_we[C_HI] ? r_m_hi : (r_w_we[C_HI] ? r_w_hi : r_arch_hi);
    assign lo_fwd  = r_m_we[C_LO] ? r_m_lo : (r_w_we[C_LO] ? r_w_lo : r_arch_lo);
    assign arch_hi = r_arch_hi;
    assign arch_lo = r_arch_lo;
    assign pending = (|r_m_we) | (|r_w_we);

endmodule
`default_nettype wire

// File: tb/tb_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_unit
// Description : Directed and randomized bench for hilo_unit with a
//               slot-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [1:0]  ex_we;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [31:0] hi_fwd;
    logic [31:0] lo_fwd;
    logic [31:0] arch_hi;
    logic [31:0] arch_lo;
    logic        pending;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    hilo_unit dut (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .flush   (flush),
        .ex_we   (ex_we),
        .ex_hi   (ex_hi),
        .ex_lo   (ex_lo),
        .hi_fwd  (hi_fwd),
        .lo_fwd  (lo_fwd),
        .arch_hi (arch_hi),
        .arch_lo (arch_lo),
        .pending (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a pending write per slot, data indexed by half
    // (1 = HI, 0 = LO).
    typedef struct packed {
        logic [1:0]       we;
        logic [1:0][31:0] d;
    } slot_t;

    slot_t            mm;
    slot_t            mw;
    logic [1:0][31:0] march;

    always @(posedge clk) begin
        if (!rst) begin
            mm    <= '0;
            mw    <= '0;
            march <= '0;
        end else begin
            for (int h = 0; h < 2; h++)
                if (mw.we[h]) march[h] <= mw.d[h];
            if (stall) mw.we <= 2'b00;
            else       mw    <= mm;
            if (flush)       mm.we <= 2'b00;
            else if (!stall) mm    <= {ex_we, ex_hi, ex_lo};
        end
    end

    function automatic logic [31:0] exp_fwd(input int h);
        if (mm.we[h]) return mm.d[h];
        if (mw.we[h]) return mw.d[h];
        return march[h];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model hi_fwd",  hi_fwd,  exp_fwd(1));
            chk("model lo_fwd",  lo_fwd,  exp_fwd(0));
            chk("model arch_hi", arch_hi, march[1]);
            chk("model arch_lo", arch_lo, march[0]);
            chk("model pending", {31'd0, pending}, {31'd0, (|mm.we) | (|mw.we)});
        end
    end

    // Applies one cycle of inputs, returns just after the consuming edge.
    task automatic drive(input logic r, input logic s, input logic f,
                         input logic [1:0] we, input logic [31:0] h, input logic [31:0] l);
        rst   = r;
        stall = s;
        flush = f;
        ex_we = we;
        ex_hi = h;
        ex_lo = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic chk_all(input string name, input logic [31:0] hf, input logic [31:0] lf,
                           input logic [31:0] ah, input logic [31:0] al, input logic p);
        chk({name, " hi_fwd"},  hi_fwd,  hf);
        chk({name, " lo_fwd"},  lo_fwd,  lf);
        chk({name, " arch_hi"}, arch_hi, ah);
        chk({name, " arch_lo"}, arch_lo, al);
        chk({name, " pending"}, {31'd0, pending}, {31'd0, p});
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        ex_we = 2'b11; ex_hi = 32'hFFFF_FFFF; ex_lo = 32'hFFFF_FFFF;

        // Reset with an active request present
        drive(1'b0, 1'b0, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cmp_en = 1;
        chk_all("reset1", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk_all("reset2", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        idle();
        chk_all("idle", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

        // Single MULT write
        drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_0001, 32'hFFFF_FFFE);
        chk_all("mult N+1", 32'h1, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b1);
        idle();
        chk_all("mult N+2", 32'h1, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b1);
        idle();
        chk_all("mult N+3", 32'h1, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFE, 1'b0);

        // MADD chain: M wins over W
        drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h1, 32'h2);
        chk("chain A hi_fwd", hi_fwd, 32'h1);
        chk("chain A lo_fwd", lo_fwd, 32'h2);
        drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h3, 32'h4);
        chk("chain B hi_fwd", hi_fwd, 32'h3);
        chk("chain B lo_fwd", lo_fwd, 32'h4);
        idle(); idle(); idle();
        chk_all("chain final", 32'h3, 32'h4, 32'h3, 32'h4, 1'b0);

        // Partial write: MTHI leaves LO untouched, disabled LO data ignored
        drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h11, 32'h55);
        drive(1'b1, 1'b0, 1'b0, 2'b10, 32'hAA, 32'h77);
        chk("partial lo_fwd", lo_fwd, 32'h55);
        idle(); idle(); idle();
        chk_all("partial final", 32'hAA, 32'h55, 32'hAA, 32'h55, 1'b0);

        // Stall three cycles holding X in M; requests during stall rejected
        drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h7, 32'h8);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 2'b11, 32'hDEAD_0000, 32'hBEEF_0000);
            chk_all("stall hold", 32'h7, 32'h8, 32'hAA, 32'h55, 1'b1);
        end
        idle();
        chk_all("stall release", 32'h7, 32'h8, 32'hAA, 32'h55, 1'b1);
        idle();
        chk_all("stall commit", 32'h7, 32'h8, 32'h7, 32'h8, 1'b0);

        // Flush together with request Z: Y commits, Z never appears
        drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h9, 32'h9);
        drive(1'b1, 1'b0, 1'b1, 2'b11, 32'h5A5A_5A5A, 32'hA5A5_A5A5);
        chk_all("flush W", 32'h9, 32'h9, 32'h7, 32'h8, 1'b1);
        idle();
        chk_all("flush commit", 32'h9, 32'h9, 32'h9, 32'h9, 1'b0);
        idle();
        chk_all("flush after", 32'h9, 32'h9, 32'h9, 32'h9, 1'b0);

        // Flush while stalled drops M
        drive(1'b1, 1'b0, 1'b0, 2'b01, 32'h0, 32'h33);
        drive(1'b1, 1'b1, 1'b1, 2'b11, 32'h44, 32'h44);
        chk_all("stall+flush", 32'h9, 32'h9, 32'h9, 32'h9, 1'b0);

        // Reset mid-operation loses pending writes
        drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h123, 32'h456);
        idle();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        chk_all("mid reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        idle(); idle();
        chk_all("mid reset after", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 63) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0,
                  2'($urandom_range(0, 3)),
                  $urandom, $urandom);
        end
        idle(); idle(); idle();

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hilo_unit.md
# hilo_unit

HI/LO write pipeline and register unit for the EX stage. It takes per-half HI/LO write requests produced in EX (multiply and multiply-accumulate results, divide results, MTHI/MTLO) and carries them through MEM and WB slots. It commits them to the architectural HI/LO pair at the end of WB. It also drives the forwarded `hi`/`lo` operands back into the EX-stage multiplier so that back-to-back MADD/MSUB chains see the newest value.

## Interface
- No parameters; data width fixed at 32 bits per half.
- `clk` in 1 — core clock, all state updates on rising edge.
- `rst` in 1 — reset, synchronous, active-low.
- `stall` in 1 — EX/MEM hold. EX request not accepted; M slot holds.
- `flush` in 1 — exception/ERET flush. Discards EX request and M slot.
- `ex_we` in 2 — EX write request; bit 1 = HI, bit 0 = LO.
- `ex_hi` in 32 — HI data from EX (`result_mult[63:32]`, divide remainder, or MTHI operand).
- `ex_lo` in 32 — LO data from EX (`result_mult[31:0]`, divide quotient, or MTLO operand).
- `hi_fwd` out 32 — forwarded HI for the EX-stage consumer.
- `lo_fwd` out 32 — forwarded LO for the EX-stage consumer.
- `arch_hi` out 32 — committed HI register.
- `arch_lo` out 32 — committed LO register.
- `pending` out 1 — any write enable set in the M or W slot.

## Operation
- State:
  - M slot: `m_we[1:0]`, `m_hi`, `m_lo`.
  - W slot: `w_we[1:0]`, `w_hi`, `w_lo`.
  - Architectural registers: `arch_hi`, `arch_lo`.
- Per rising edge, priority order:
  1. `rst`=0: all slot enables, data and architectural registers cleared to 0.
  2. Commit, unconditional: if `w_we[1]`, `arch_hi`←`w_hi`; if `w_we[0]`, `arch_lo`←`w_lo`.
  3. W slot:
     - `stall`=0: W←M, even when `flush`=1, because the instruction leaving M is past the exception point.
     - `stall`=1: W←bubble (`w_we`=0). Data is don't-care but held.
  4. M slot:
     - `flush`=1: M←bubble. Flush overrides stall.
     - else `stall`=0: M←{`ex_we`,`ex_hi`,`ex_lo`}.
     - else `stall`=1: M holds.
- Per-half independence: a write with `we`=2'b10 updates only HI at commit. LO keeps its prior value, and vice versa. Data on a disabled half is ignored, never committed or forwarded.
- Forwarding, combinational from registered state, independently per half:
  - `hi_fwd` = `m_we[1]` ? `m_hi` : `w_we[1]` ? `w_hi` : `arch_hi`. `lo_fwd` is analogous with bit 0.
  - The M slot is newest and wins over W; W wins over architectural.
  - EX inputs are never forwarded combinationally, so there is no EX→EX loop through the multiplier.
- `pending` = |`m_we` | |`w_we`.
- No arithmetic in this block; all data is passed through unmodified.

## Timing
- Reset values: `hi_fwd`, `lo_fwd`, `arch_hi`, `arch_lo` = 0; `pending` = 0.
- Latency with no stalls:
  - Request presented in cycle N is in M at N+1 and visible on `*_fwd` from N+1.
  - It is in W at N+2.
  - It is visible on `arch_*` from N+3.
- Back-to-back writers: the consumer in EX at N+1 sees the cycle-N result via the M slot.
- Stall, held k cycles:
  - M contents and forwarding stay stable.
  - The W slot drains after one cycle; `arch_*` updates at most once during the stall.
- Flush in the same cycle as an EX request: the request is dropped, the M slot is dropped, and the W slot still commits next edge.
- Reset mid-operation: pending M/W writes are lost, with no partial commit.

## Test plan
- Reset then idle: hold `rst`=0 two cycles with `ex_we`=3 and data 0xFFFFFFFF → all outputs 0 and `pending`=0. Release reset with `ex_we`=0 → outputs stay 0.
- Single MULT write: cycle N drives `ex_we`=3, HI=0x00000001, LO=0xFFFFFFFE.
  - `hi_fwd`/`lo_fwd` = those values from N+1.
  - `arch_*` = those values from N+3.
  - `pending` = 1 for N+1..N+2.
- MADD chain: write A (HI=1, LO=2) at N, then B (HI=3, LO=4) at N+1.
  - At N+1, `hi_fwd`/`lo_fwd` = 1/2.
  - At N+2, `hi_fwd`/`lo_fwd` = 3/4 (M wins over W).
  - Final `arch` = 3/4.
- Partial write: LO=0x55 with `ex_we`=3, then MTHI HI=0xAA with `ex_we`=2'b10 → final `arch_hi`=0xAA, `arch_lo`=0x55.
- Stall and flush:
  - Write X (HI=7, LO=8) then assert `stall` three cycles → `arch` updates once, and `hi_fwd` stays 7 throughout.
  - Write Y (HI=9, LO=9), then `flush` in the next cycle together with a new request Z → Y commits, Z is never visible on any output.
